// File: rtl/pe_kxc_if.sv
// Pixel stream bundle for pe_kxc: upstream pixel/valid/sof in, processed lanes and enable out.
interface pe_kxc_if #(
    parameter int CL_IN = 4,
    parameter int N     = 4
);
    logic [CL_IN*N-1:0] d_in;
    logic               d_valid;
    logic               sof;
    logic [CL_IN*N-1:0] d_out;
    logic               en_out;

    modport master (output d_in, d_valid, sof, input  d_out, en_out);
    modport slave  (input  d_in, d_valid, sof, output d_out, en_out);
endinterface

// File: rtl/pe_kxc.sv
// CL_IN-channel 3x3 convolution PE: line buffers, window tracking, 3-stage MAC pipeline,
// shift/ReLU/saturate post-processing, bypass lanes and daisy-chained weights/config.
module pe_kxc #(
    parameter int LINES = 16,
    parameter int CL_IN = 4,
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int SR    = 2,
    parameter int RELU  = 1,
    parameter int SAT   = 1,
    parameter int SW    = (CL_IN > 1) ? $clog2(CL_IN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    pe_kxc_if.slave            bus,
    input  logic [CL_IN*M-1:0] w_in,
    input  logic               w_conf,
    output logic [CL_IN*M-1:0] w_out,
    input  logic               cntl_conf,
    input  logic [CL_IN-1:0]   d_ch_in,
    input  logic [CL_IN-1:0]   bp_ch_in,
    input  logic [SW-1:0]      bp_src_in,
    output logic [CL_IN-1:0]   d_ch_out,
    output logic [CL_IN-1:0]   bp_ch_out,
    output logic [SW-1:0]      bp_src_out
);
    localparam int CW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int PW = N + M;
    localparam int AW = N + M + $clog2(9 * CL_IN);
    localparam logic signed [AW-1:0] P_MAX = AW'((2 ** (N - 1)) - 1);
    localparam logic signed [AW-1:0] P_MIN = AW'(-(2 ** (N - 1)));

    logic [CL_IN-1:0]    r_d_ch, r_bp_ch;
    logic [SW-1:0]       r_bp_src;
    logic signed [M-1:0] r_tap  [CL_IN][9];
    logic signed [N-1:0] r_lb_a [CL_IN][LINES];
    logic signed [N-1:0] r_lb_b [CL_IN][LINES];
    logic signed [N-1:0] r_win  [CL_IN][3][3];
    logic [CW-1:0]       r_col;
    logic [1:0]          r_row;

    logic                w_acc, w_wv;
    logic [CW-1:0]       w_col;
    logic [1:0]          w_row;
    logic [N-1:0]        w_bp_dat;

    logic                r_vld_p0, r_wv_p0;
    logic [CL_IN-1:0]    r_chm_p0, r_bpm_p0;
    logic [N-1:0]        r_bpd_p0;

    logic signed [PW-1:0] r_prod_p1 [CL_IN][9];
    logic                 r_vld_p1, r_wv_p1;
    logic [CL_IN-1:0]     r_bpm_p1;
    logic [N-1:0]         r_bpd_p1;

    logic signed [AW-1:0] w_sum;
    logic [N-1:0]         w_res;
    logic [CL_IN*N-1:0]   r_d_out;
    logic                 r_en_out;

    function automatic logic [N-1:0] f_post(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] res;
        res = acc >>> SR;
        if (RELU != 0 && res[AW-1]) res = '0;
        if (SAT != 0) begin
            if (res > P_MAX)      res = P_MAX;
            else if (res < P_MIN) res = P_MIN;
        end
        return res[N-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_ch   <= '0;
            r_bp_ch  <= '0;
            r_bp_src <= '0;
        end else if (cntl_conf) begin
            r_d_ch   <= d_ch_in;
            r_bp_ch  <= bp_ch_in;
            r_bp_src <= bp_src_in;
        end
    end

    assign d_ch_out   = r_d_ch;
    assign bp_ch_out  = r_bp_ch;
    assign bp_src_out = r_bp_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < CL_IN; ch++)
                for (int k = 0; k < 9; k++)
                    r_tap[ch][k] <= '0;
        end else if (w_conf) begin
            for (int ch = 0; ch < CL_IN; ch++) begin
                r_tap[ch][0] <= w_in[ch*M +: M];
                for (int k = 1; k < 9; k++)
                    r_tap[ch][k] <= r_tap[ch][k-1];
            end
        end
    end

    always_comb begin
        w_out = '0;
        for (int ch = 0; ch < CL_IN; ch++)
            w_out[ch*M +: M] = r_tap[ch][8];
    end

    // A sof pixel is placed at the frame origin regardless of where the counters stood.
    assign w_acc = bus.d_valid && (r_d_ch != '0);
    assign w_col = bus.sof ? '0 : r_col;
    assign w_row = bus.sof ? 2'd0 : r_row;
    assign w_wv  = (w_row == 2'd2) && (w_col >= CW'(2));

    always_comb begin
        w_bp_dat = '0;
        for (int i = 0; i < CL_IN; i++)
            if (r_bp_src == SW'(i)) w_bp_dat = bus.d_in[i*N +: N];
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int ch = 0; ch < CL_IN; ch++) begin
                if (r_d_ch[ch]) begin
                    r_lb_b[ch][w_col] <= r_lb_a[ch][w_col];
                    r_lb_a[ch][w_col] <= bus.d_in[ch*N +: N];
                end
            end
        end
    end

    // Stage p0: pixel sampled, window shifted, counters advanced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_vld_p0 <= 1'b0;
            r_wv_p0  <= 1'b0;
            r_chm_p0 <= '0;
            r_bpm_p0 <= '0;
            r_bpd_p0 <= '0;
            for (int ch = 0; ch < CL_IN; ch++)
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        r_win[ch][rr][cc] <= '0;
        end else begin
            r_vld_p0 <= w_acc && (w_wv || (r_bp_ch != '0));
            r_wv_p0  <= w_acc && w_wv;
            r_chm_p0 <= r_d_ch;
            r_bpm_p0 <= r_bp_ch;
            r_bpd_p0 <= w_bp_dat;
            if (w_acc) begin
                if (w_col == CW'(LINES - 1)) begin
                    r_col <= '0;
                    r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
                for (int ch = 0; ch < CL_IN; ch++) begin
                    if (r_d_ch[ch]) begin
                        for (int rr = 0; rr < 3; rr++) begin
                            r_win[ch][rr][0] <= r_win[ch][rr][1];
                            r_win[ch][rr][1] <= r_win[ch][rr][2];
                        end
                        r_win[ch][0][2] <= r_lb_b[ch][w_col];
                        r_win[ch][1][2] <= r_lb_a[ch][w_col];
                        r_win[ch][2][2] <= bus.d_in[ch*N +: N];
                    end
                end
            end
        end
    end

    // Stage p1: products; window position p pairs with tap 8-p.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_wv_p1  <= 1'b0;
            r_bpm_p1 <= '0;
            r_bpd_p1 <= '0;
            for (int ch = 0; ch < CL_IN; ch++)
                for (int p = 0; p < 9; p++)
                    r_prod_p1[ch][p] <= '0;
        end else begin
            r_vld_p1 <= r_vld_p0;
            r_wv_p1  <= r_wv_p0;
            r_bpm_p1 <= r_bpm_p0;
            r_bpd_p1 <= r_bpd_p0;
            for (int ch = 0; ch < CL_IN; ch++)
                for (int p = 0; p < 9; p++)
                    if (r_chm_p0[ch])
                        r_prod_p1[ch][p] <= PW'(r_win[ch][p/3][p%3]) * PW'(r_tap[ch][8-p]);
                    else
                        r_prod_p1[ch][p] <= '0;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int ch = 0; ch < CL_IN; ch++)
            for (int p = 0; p < 9; p++)
                w_sum = w_sum + AW'(r_prod_p1[ch][p]);
    end

    assign w_res = f_post(w_sum);

    // Stage p2: lanes registered; d_out holds between valid results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_out  <= '0;
            r_en_out <= 1'b0;
        end else begin
            r_en_out <= r_vld_p1;
            if (r_vld_p1) begin
                for (int i = 0; i < CL_IN; i++)
                    if (r_bpm_p1[i])  r_d_out[i*N +: N] <= r_bpd_p1;
                    else if (r_wv_p1) r_d_out[i*N +: N] <= w_res;
                    else              r_d_out[i*N +: N] <= '0;
            end
        end
    end

    assign bus.d_out  = r_d_out;
    assign bus.en_out = r_en_out;
endmodule

// File: tb/tb_pe_kxc.sv
// Randomised bench for pe_kxc against a frame-level convolution model with a 2-cycle output pipe.
module tb_pe_kxc;
    localparam int LINES = 16;
    localparam int CL    = 4;
    localparam int N     = 4;
    localparam int M     = 4;
    localparam int SR    = 2;
    localparam int RELU  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_kxc_if #(.CL_IN(CL), .N(N)) bus ();
    logic [CL*M-1:0] w_in, w_out;
    logic            w_conf, cntl_conf;
    logic [CL-1:0]   d_ch_in, bp_ch_in, d_ch_out, bp_ch_out;
    logic [1:0]      bp_src_in, bp_src_out;

    pe_kxc #(.LINES(LINES), .CL_IN(CL), .N(N), .M(M), .SR(SR), .RELU(RELU), .SAT(1)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .w_in(w_in), .w_conf(w_conf), .w_out(w_out),
        .cntl_conf(cntl_conf), .d_ch_in(d_ch_in), .bp_ch_in(bp_ch_in), .bp_src_in(bp_src_in),
        .d_ch_out(d_ch_out), .bp_ch_out(bp_ch_out), .bp_src_out(bp_src_out)
    );

    int n_tests, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [15:0] k;
    } ent_t;

    logic [3:0]  m_dch, m_bpch;
    logic [1:0]  m_bpsrc;
    int          wq [CL][$];
    int          img [CL][3][LINES];
    int          m_row, m_col;
    ent_t        pipe0, pipe1;
    logic [15:0] m_dout, m_known;

    function automatic int sx(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int wt(input int ch, input int p);
        return wq[ch][wq[ch].size() - 9 + p];
    endfunction

    function automatic int post(input int acc);
        int r;
        r = acc >>> SR;
        if (RELU != 0 && r < 0) r = 0;
        if (r > (1 << (N - 1)) - 1) r = (1 << (N - 1)) - 1;
        if (r < -(1 << (N - 1)))    r = -(1 << (N - 1));
        return r;
    endfunction

    task automatic model_reset();
        m_dch = '0; m_bpch = '0; m_bpsrc = '0;
        for (int ch = 0; ch < CL; ch++) begin
            wq[ch].delete();
            repeat (9) wq[ch].push_back(0);
        end
        m_row = 0; m_col = 0;
        pipe0.v = 1'b0; pipe0.d = '0; pipe0.k = '0;
        pipe1 = pipe0;
        m_dout = '0; m_known = '1;
    endtask

    task automatic cyc();
        ent_t e, o;
        int r, c, acc;
        logic valid;
        logic [3:0] res4, bpv;
        logic [15:0] wexp;
        e.v = 1'b0; e.d = '0; e.k = '0;
        o = e;
        if (!rst) begin
            if (bus.d_valid && m_dch != 4'd0) begin
                c = bus.sof ? 0 : m_col;
                r = bus.sof ? 0 : m_row;
                for (int ch = 0; ch < CL; ch++)
                    if (m_dch[ch]) img[ch][r % 3][c] = sx(bus.d_in[ch*N +: N]);
                valid = (r >= 2) && (c >= 2);
                res4 = '0;
                if (valid) begin
                    acc = 0;
                    for (int ch = 0; ch < CL; ch++)
                        if (m_dch[ch])
                            for (int p = 0; p < 9; p++)
                                acc += img[ch][(r - 2 + p / 3) % 3][c - 2 + p % 3] * wt(ch, p);
                    res4 = 4'(post(acc));
                end
                bpv = (int'(m_bpsrc) < CL) ? bus.d_in[m_bpsrc*N +: N] : 4'd0;
                for (int i = 0; i < CL; i++) begin
                    if (m_bpch[i]) begin
                        e.d[i*N +: N] = bpv; e.k[i*N +: N] = '1;
                    end else if (valid) begin
                        e.d[i*N +: N] = res4; e.k[i*N +: N] = '1;
                    end
                end
                e.v = valid || (m_bpch != 4'd0);
                if (c == LINES - 1) begin m_col = 0; m_row = r + 1; end
                else begin m_col = c + 1; m_row = r; end
            end
            if (w_conf)
                for (int ch = 0; ch < CL; ch++) wq[ch].push_back(sx(w_in[ch*M +: M]));
            if (cntl_conf) begin m_dch = d_ch_in; m_bpch = bp_ch_in; m_bpsrc = bp_src_in; end
        end
        @(posedge clk);
        if (!rst) begin
            o = pipe1; pipe1 = pipe0; pipe0 = e;
            if (o.v) begin m_dout = o.d; m_known = o.k; end
        end
        #1;
        for (int ch = 0; ch < CL; ch++) wexp[ch*M +: M] = 4'(wt(ch, 0));
        chk("en_out",  32'(bus.en_out), 32'(o.v));
        chk("d_out",   32'(bus.d_out & m_known), 32'(m_dout & m_known));
        chk("w_out",   32'(w_out), 32'(wexp));
        chk("cfg_out", 32'({d_ch_out, bp_ch_out, bp_src_out}), 32'({m_dch, m_bpch, m_bpsrc}));
    endtask

    task automatic idle();
        bus.d_valid = 1'b0; bus.sof = 1'b0; w_conf = 1'b0; cntl_conf = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (3) cyc();
    endtask

    task automatic cfg_load(input logic [3:0] dch, input logic [3:0] bpch, input logic [1:0] src);
        idle();
        cntl_conf = 1'b1; d_ch_in = dch; bp_ch_in = bpch; bp_src_in = src;
        cyc();
        cntl_conf = 1'b0;
    endtask

    task automatic load_w(input logic [15:0] w);
        idle();
        w_conf = 1'b1; w_in = w;
        cyc();
        w_conf = 1'b0;
    endtask

    task automatic pix(input logic [15:0] d, input logic s);
        w_conf = 1'b0; cntl_conf = 1'b0;
        bus.d_valid = 1'b1; bus.d_in = d; bus.sof = s;
        cyc();
        bus.d_valid = 1'b0; bus.sof = 1'b0;
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_en_out", 32'(bus.en_out), 32'd0);
        chk("rst_d_out",  32'(bus.d_out), 32'd0);
        idle();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit first;
        n_tests = 0; n_fail = 0;
        bus.d_in = '0; w_in = '0; d_ch_in = '0; bp_ch_in = '0; bp_src_in = '0;
        idle();
        rst = 1'b1;
        model_reset();

        // reset held with random activity on every input
        repeat (4) begin
            bus.d_in = 16'($urandom); bus.d_valid = 1'($urandom); bus.sof = 1'($urandom);
            w_in = 16'($urandom); w_conf = 1'($urandom); cntl_conf = 1'($urandom);
            d_ch_in = 4'($urandom); bp_ch_in = 4'($urandom); bp_src_in = 2'($urandom);
            cyc();
        end
        idle();
        rst = 1'b0;
        repeat (5) begin
            bus.d_in = 16'($urandom); bus.d_valid = 1'($urandom); bus.sof = 1'($urandom);
            cyc();
        end

        // cntl capture and weight chain
        cfg_load(4'b0001, 4'b1000, 2'd0);
        for (int k = 1; k <= 9; k++) load_w({12'h000, 4'(k)});
        chk("wchain_9", 32'(w_out[3:0]), 32'd1);
        load_w(16'h0001);
        chk("wchain_10", 32'(w_out[3:0]), 32'd2);
        repeat (8) load_w(16'h0001);

        // basic convolution, all ones
        for (int i = 0; i < 64; i++) begin
            pix(16'h1111, i == 0);
            if (i == 36) chk("conv_first", 32'({bus.en_out, bus.d_out}), 32'h11222);
        end
        drain();

        // saturation high, then ReLU on negative
        cfg_load(4'hF, 4'h0, 2'd0);
        repeat (9) load_w(16'h7777);
        for (int i = 0; i < 40; i++) begin
            pix(16'h7777, i == 0);
            if (i == 36) chk("sat_pos", 32'({bus.en_out, bus.d_out}), 32'h17777);
        end
        drain();
        repeat (9) load_w(16'h8888);
        for (int i = 0; i < 40; i++) begin
            pix(16'h7777, i == 0);
            if (i == 36) chk("relu_neg", 32'({bus.en_out, bus.d_out}), 32'h10000);
        end
        drain();

        // sof in the middle of row 5
        cfg_load(4'hF, 4'h0, 2'd0);
        repeat (9) load_w(16'($urandom));
        for (int i = 0; i < 16 * 5 + 9; i++) pix(16'($urandom), i == 0);
        for (int i = 0; i < 60; i++) pix(16'($urandom), i == 0);
        drain();

        // reset in the middle of a stream, then restart without sof
        cfg_load(4'b0111, 4'b0100, 2'd1);
        repeat (9) load_w(16'($urandom));
        for (int i = 0; i < 50; i++) pix(16'($urandom), i == 0);
        pulse_rst();
        cfg_load(4'hF, 4'h0, 2'd0);
        repeat (9) load_w(16'($urandom));
        for (int i = 0; i < 45; i++) pix(16'($urandom), 1'b0);
        drain();

        // random segments with gaps and occasional sof
        repeat (4) begin
            cfg_load(4'($urandom_range(1, 15)), 4'($urandom), 2'($urandom));
            repeat (9) load_w(16'($urandom));
            first = 1'b1;
            repeat (150) begin
                if ($urandom_range(0, 3) != 0) begin
                    pix(16'($urandom), first || ($urandom_range(0, 63) == 0));
                    first = 1'b0;
                end else begin
                    idle();
                    bus.d_in = 16'($urandom);
                    cyc();
                end
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_kxc.md
# pe_kxc

Parametrised next-generation processing element. It is a CL_IN-channel 3x3 convolution PE with internal line buffers, row/column tracking and a 3-stage registered MAC pipeline. Compared with the current PE it adds an explicit input valid, window-valid gating, start-of-frame handling, output saturation, and registered bypass lanes with a generalised source select. It sits in the PE array between the frame feeder and the next PE, and daisy-chains weights and control configuration.

## Interface
- LINES, 16: pixels per input line; sets line-buffer depth.
- CL_IN, 4: number of input/output channels (lanes).
- N, 4: data width, signed.
- M, 4: weight width, signed.
- SR, 2: arithmetic right shift applied to the accumulator before output.
- RELU, 1: 1 clamps negative results to 0.
- SAT, 1: 1 saturates to the N-bit signed range; 0 keeps bits [SR+N-1:SR].
- SW, max(1,$clog2(CL_IN)): width of the bypass source select.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- d_in  in  CL_IN*N  pixel per channel; lane i is [i*N+:N].
- d_valid  in  1  the pixel on d_in is valid this cycle.
- sof  in  1  start of frame; qualified by d_valid.
- w_in  in  CL_IN*M  weight shift input per channel.
- w_conf  in  1  weight shift enable.
- w_out  out  CL_IN*M  weight chain output (tap 8 per channel).
- cntl_conf  in  1  capture control configuration.
- d_ch_in  in  CL_IN  channel enable mask.
- bp_ch_in  in  CL_IN  per-lane bypass select.
- bp_src_in  in  SW  bypass source channel.
- d_ch_out, bp_ch_out  out  CL_IN  registered configuration copies, for chaining.
- bp_src_out  out  SW  registered configuration copy, for chaining.
- d_out  out  CL_IN*N  output lanes.
- en_out  out  1  d_out is valid this cycle.

## Operation
- **Reset:** every register, every output and the d_ch, bp_ch and bp_src registers clear to 0. Line-buffer contents are not reset; stale contents are masked by the row counter.
- **Control config:**
  - Each edge with cntl_conf=1 loads d_ch, bp_ch and bp_src and their *_out copies from the *_in ports.
  - Values take effect from the next cycle.
  - Holding cntl_conf high recaptures every cycle.
  - Configuration does not reset the counters or the pipeline.
- **Weights:**
  - Each channel has a 9-tap shift register. On w_conf=1: tap0<=w_in lane, tapk<=tap(k-1).
  - w_out lane = tap8.
  - Window position p = 3*r+c (r=0 is the oldest row, c=0 is the oldest column) multiplies tap(8-p), so the first weight shifted in pairs with the oldest pixel.
- **Data accept:** a pixel is accepted when d_valid=1 and d_ch != 0.
  - Enabled channels write the line buffers and shift the 3x3 window.
  - Disabled channels contribute 0 to the sum.
  - With d_ch=0 nothing advances.
- **Counters:** col runs 0..LINES-1 and wraps to 0, incrementing row. row saturates at 2.
  - An accepted pixel with sof=1 is treated as col=0, row=0.
- **Window valid:** the accepted pixel produces a result iff, at its own position, row==2 and col>=2.
- **Arithmetic:**
  - Products d*w are signed N+M bits.
  - The sum runs over 9*CL_IN products with accumulator width N+M+$clog2(9*CL_IN).
  - res = acc >>> SR.
  - If RELU and res<0, res=0.
  - If SAT, clamp res to [-2^(N-1), 2^(N-1)-1]; otherwise take the low N bits of res.
- **Lane output:**
  - Lane i with bp_ch[i]=0 carries res.
  - Lane i with bp_ch[i]=1 carries d_in[bp_src] from the accepted cycle, delayed through the same pipeline. It carries 0 if bp_src>=CL_IN.
- **en_out:** asserted for a result pixel, or for any accepted pixel when bp_ch != 0.
- **Simultaneous w_conf and d_valid:** both proceed with no interlock. In-flight products use the taps as they are at the product stage.

## Timing
- **Pipeline stages:**
  - Edge k: pixel sampled and window updated.
  - Edge k+1: products registered.
  - Edge k+2: d_out and en_out registered.
- en_out is high for exactly one cycle after edge k+2 per accepted pixel. Back-to-back accepted pixels give back-to-back en_out.
- d_out holds its last value while en_out=0.
- rst asserted mid-stream clears en_out and d_out immediately (asynchronously). After release, row=0 and the first result needs a full 2*LINES+3 accepted pixels.
- Config outputs (*_out) lag cntl_conf by 1 edge. w_out lags w_in by 9 w_conf edges.

## Test plan
All scenarios use CL_IN=4, N=4, M=4, SR=2, LINES=16.
- **Reset:** hold rst with random inputs -> all outputs 0. Release -> outputs stay 0 until configured.
- **Config and weight chain:** cntl_conf pulse with d_ch_in=0001, bp_ch_in=1000, bp_src_in=0 -> *_out match next cycle. Shift weights 1..9 on lane0 -> w_out lane0=1 after the 9th edge, 2 after the 10th.
- **Basic conv:** ch0 weights all 1, pixels all 1, sof on the first pixel -> first en_out 2 cycles after pixel index 34 is sampled. Lanes 0-2 read 2 (9>>2); lane3 (bypass) reads 1. One en_out per pixel from then on.
- **Saturation and ReLU:** all 4 channels enabled, weights 7, data 7 -> 1764>>2 saturates to 7. Weights -8, data 7 -> 0 with RELU=1; -8 with RELU=0, SAT=1.
- **Mid-row sof:** sof at col 9 of row 5 -> no compute en_out for the next 34 accepted pixels, then results resume.
- **Gaps and reset mid-stream:** d_valid toggled 1-0-1 -> en_out follows with a 2-edge lag and counters do not advance on gaps. rst pulse mid-row -> en_out low at once, and the first result again needs 35 accepted pixels.
